wb_digpot_mc: RTL and testbench
===============================

# wb_digpot_mc

Multi-channel Wishbone controller for up/down-counter digital potentiometers (INC / U/Dn / CSn interface, X9C-class). Each of NCH channels tracks its wiper position, accepts an absolute target, and generates the exact pulse sequence to reach it. It also supports a homing sweep and an optional non-volatile store on deselect. It is a Wishbone slave on the SoC peripheral bus, driving one potentiometer per channel.

## Interface
- NCH, 2, number of channels (1..8)
- DIV, 50, clk cycles per pulse phase (≥2)
- MAX_POS, 99, highest wiper position (≤127)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone strobe / cycle / write enable
- wb_adr_i  in  32  byte address; [2] register select, [5:3] channel
- wb_sel_i  in  4  byte selects; ignored, full-word access only
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  = wb_stb_i & wb_cyc_i & internal ack
- inc_o  out  NCH  INC per channel; wiper moves on falling edge while csn low
- udn_o  out  NCH  direction per channel: 1 up, 0 down
- csn_o  out  NCH  chip select per channel, active low

## Operation
- **Register map, per channel c at byte offset 8c:**
  - +0 TARGET. W: [6:0] target, clamped to MAX_POS; [8] store-on-deselect. R: [6:0] target, [8] store.
  - +4 STATUS. W: [0]=1 starts a home. R: [6:0] pos, [8] busy, [9] homed, [10] rejected.
- Channel index ≥ NCH: write acked and ignored; read returns 0.
- Bus access: internal ack is set for one cycle when stb&cyc&~ack, so every access takes exactly 2 cycles. Write side effects and wb_dat_o both update on the ack edge. wb_dat_o[31:11] is always 0.
- **Per-channel FSM.** Each phase lasts exactly DIV cycles, timed by a per-channel counter.
  - IDLE: csn=1, inc=1. Goes to SETUP when pos≠target or a home is pending; latches dir.
  - SETUP: csn=0, udn=dir, inc=1.
  - INC_LO: inc=0. At phase end, pos±1 (up/down per dir); during a home, pos is not changed.
  - INC_HI: inc=1. At phase end:
    - home with steps remaining, or pos≠target in the same dir → INC_LO;
    - otherwise → END.
  - END: csn=0, inc = store ? 1 : 0.
  - DESEL: csn=1, inc as in END. Then → IDLE, and store clears.
- **Home:** the channel performs MAX_POS+1 down steps. It then sets pos=0, target=0, homed=1.
- Writing TARGET while busy updates the target immediately. The new target is evaluated only at the INC_HI end.
  - A direction reversal goes through END/DESEL, then SETUP; udn never changes while csn is low.
- A home write while busy is ignored and sets rejected. Rejected clears on the next accepted home or TARGET write.
- pos saturates to 0..MAX_POS. Target writes above MAX_POS are stored as MAX_POS.

## Timing
- Reset values (asynchronous):
  - wb_ack_o=0, wb_dat_o=0;
  - inc_o, csn_o all ones; udn_o all zeros;
  - pos, target, store, homed, rejected = 0; all FSMs in IDLE.
- Reset asserted mid-sequence forces the outputs above immediately, with no store pulse.
- Write ack at edge k → busy=1 and SETUP entered at edge k+1 (if a move is required).
- A move of N steps lasts (2N+3)·DIV cycles from SETUP entry to IDLE.
- The first inc falling edge is DIV cycles after csn falls.
- Home takes (2(MAX_POS+1)+3)·DIV cycles.
- Channels run fully independently; simultaneous activity on all NCH channels is legal.
- The STATUS read value is sampled on the ack edge. pos reflects the update made at the end of INC_LO.

## Test plan
- **Reset defaults:** reset=0 mid-move → next cycle inc_o=all 1, csn_o=all 1, udn_o=0. STATUS reads 0.
- **Up move:** DIV=4; write TARGET=0x005 to ch0.
  - Expect csn0 low, udn0=1, and 5 inc0 low pulses of 4 cycles each.
  - busy for 52 cycles; STATUS=0x005 afterwards; ch1 outputs unchanged.
- **Store and down move:** from pos 5, write 0x102 to ch0.
  - Expect udn0=0 and 3 pulses.
  - At the csn0 rising edge, inc0=1 (store). TARGET reads 0x002 afterwards.
- **Reversal and clamp:**
  - During a move to 10, write target 2 at pos 4 → expect END/DESEL, then SETUP with udn=0; final pos=2.
  - Write 0x07F → TARGET reads MAX_POS (99).
- **Home:** write STATUS[0]=1 → expect 100 down pulses and STATUS=0x200 (homed, pos 0).
  - A second home while busy sets the rejected bit (0x500 during busy).
- **Bus edge cases:**
  - A write to channel 5 with NCH=2 is acked in 2 cycles with no effect; a read from it returns 0.
  - Back-to-back stb held high → ack toggles 1,0,1.

Source files
------------

// File: rtl/wb_digpot_mc.sv
// rtl/wb_digpot_mc.sv - Wishbone controller for X9C-class INC/UDn/CSn digital potentiometers
// Each channel tracks its wiper, steps toward an absolute target, and supports homing and store-on-deselect.
module wb_digpot_mc #(
  parameter int NCH     = 2,
  parameter int DIV     = 50,
  parameter int MAX_POS = 99
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  input  logic           wb_we_i,
  input  logic [31:0]    wb_adr_i,
  input  logic [3:0]     wb_sel_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  output logic           wb_ack_o,
  output logic [NCH-1:0] inc_o,
  output logic [NCH-1:0] udn_o,
  output logic [NCH-1:0] csn_o
);
  localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] PH_LAST    = CW'(DIV - 1);
  localparam logic [6:0]    POS_MAX    = 7'(MAX_POS);
  localparam logic [7:0]    HOME_STEPS = 8'(MAX_POS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_INC_LO, S_INC_HI, S_END, S_DESEL
  } state_t;

  logic        ack_int;
  logic        acc;
  logic [2:0]  chan;
  logic        reg_sel;
  logic [6:0]  tgt_in;
  logic [31:0] rd_target [8];
  logic [31:0] rd_status [8];
  logic        unused_bits;

  assign acc      = wb_stb_i & wb_cyc_i & ~ack_int;
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_int;
  assign chan     = wb_adr_i[5:3];
  assign reg_sel  = wb_adr_i[2];
  assign tgt_in   = (wb_dat_i[6:0] > POS_MAX) ? POS_MAX : wb_dat_i[6:0];
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:9], wb_dat_i[7]};

  // Read data is captured on the same edge that raises the internal ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_int  <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ack_int <= acc;
      if (acc) wb_dat_o <= reg_sel ? rd_status[chan] : rd_target[chan];
    end
  end

  for (genvar c = 0; c < 8; c++) begin : g_ch
    if (c < NCH) begin : g_on
      state_t        state, state_nx;
      logic [CW-1:0] cnt;
      logic [6:0]    pos, target;
      logic [7:0]    steps;
      logic          store, homed, rejected, homing, dir;
      logic          sel, wr_tgt, wr_home, busy, phase_end, more;
      logic          inc, udn, csn;

      assign sel       = acc & wb_we_i & (chan == 3'(c));
      assign wr_tgt    = sel & ~reg_sel;
      assign wr_home   = sel & reg_sel & wb_dat_i[0];
      assign busy      = (state != S_IDLE);
      assign phase_end = (cnt == PH_LAST);
      // Continue pulsing only while the pending work keeps the latched direction.
      assign more = homing ? (steps != HOME_STEPS)
                           : (dir ? (target > pos) : (target < pos));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
      end

      always_comb begin
        state_nx = state;
        unique case (state)
          S_IDLE:   if (homing || pos != target) state_nx = S_SETUP;
          S_SETUP:  if (phase_end) state_nx = S_INC_LO;
          S_INC_LO: if (phase_end) state_nx = S_INC_HI;
          S_INC_HI: if (phase_end) state_nx = more ? S_INC_LO : S_END;
          S_END:    if (phase_end) state_nx = S_DESEL;
          S_DESEL:  if (phase_end) state_nx = S_IDLE;
          default:  state_nx = S_IDLE;
        endcase
      end

      always_comb begin
        csn = 1'b1;
        inc = 1'b1;
        udn = dir;
        unique case (state)
          S_SETUP, S_INC_HI: csn = 1'b0;
          S_INC_LO: begin csn = 1'b0; inc = 1'b0; end
          S_END:    begin csn = 1'b0; inc = store; end
          S_DESEL:  inc = store;
          default:  ;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt      <= '0;
          pos      <= '0;
          target   <= '0;
          steps    <= '0;
          store    <= 1'b0;
          homed    <= 1'b0;
          rejected <= 1'b0;
          homing   <= 1'b0;
          dir      <= 1'b0;
        end else begin
          if (state == S_IDLE || phase_end) cnt <= '0;
          else                              cnt <= cnt + 1'b1;
          if (state == S_IDLE && state_nx == S_SETUP) dir <= homing ? 1'b0 : (target > pos);
          if (state == S_INC_LO && phase_end) begin
            if (homing)                    steps <= steps + 1'b1;
            else if (dir && pos < POS_MAX) pos   <= pos + 1'b1;
            else if (!dir && pos != '0)    pos   <= pos - 1'b1;
          end
          if (state == S_INC_HI && phase_end && homing && steps == HOME_STEPS) begin
            pos    <= '0;
            target <= '0;
            homing <= 1'b0;
            homed  <= 1'b1;
          end
          if (state == S_DESEL && phase_end) store <= 1'b0;
          // Bus writes come last so a write landing on a phase boundary wins.
          if (wr_tgt) begin
            target   <= tgt_in;
            store    <= wb_dat_i[8];
            rejected <= 1'b0;
          end
          if (wr_home) begin
            if (busy || homing) rejected <= 1'b1;
            else begin
              homing   <= 1'b1;
              steps    <= '0;
              rejected <= 1'b0;
            end
          end
        end
      end

      assign rd_target[c] = {23'd0, store, 1'b0, target};
      assign rd_status[c] = {21'd0, rejected, homed, busy, 1'b0, pos};
      assign inc_o[c] = inc;
      assign udn_o[c] = udn;
      assign csn_o[c] = csn;
    end else begin : g_off
      assign rd_target[c] = '0;
      assign rd_status[c] = '0;
    end
  end
endmodule

// File: tb/tb_wb_digpot_mc.sv
// tb/tb_wb_digpot_mc.sv - directed self-checking bench for wb_digpot_mc
`timescale 1ns/1ps
module tb_wb_digpot_mc;
  localparam int NCH = 2, DIV = 4, MAX_POS = 99;

  logic           clk = 1'b0, reset = 1'b0;
  logic           stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0]    adr = '0, dat_i = '0;
  logic [3:0]     sel = 4'hf;
  logic [31:0]    dat_o;
  logic           ack;
  logic [NCH-1:0] inc, udn, csn;
  int checks = 0, errors = 0;

  wb_digpot_mc #(.NCH(NCH), .DIV(DIV), .MAX_POS(MAX_POS)) dut (
    .clk(clk), .reset(reset), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .inc_o(inc), .udn_o(udn), .csn_o(csn)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Channel 0 pin monitor: running totals only; tests take before/after deltas.
  int tot_pulses = 0, tot_ups = 0, tot_dns = 0, tot_badw = 0, tot_csn_low = 0;
  int tot_falls = 0, tot_glitch = 0, tot_ch1_bad = 0, tot_gap_bad = 0;
  int lo_cyc = 0, since_fall = 0;
  logic seen_lo = 1'b0, inc_at_rise = 1'b0;
  logic p_inc = 1'b1, p_csn = 1'b1, p_udn = 1'b0;

  always @(negedge clk) begin
    if (!csn[0]) begin
      tot_csn_low++;
      if (p_csn) begin tot_falls++; since_fall = 0; seen_lo = 1'b0; end
      since_fall++;
      if (!p_csn && udn[0] !== p_udn) tot_glitch++;
      if (!inc[0]) begin
        lo_cyc++;
        if (!seen_lo) begin seen_lo = 1'b1; if (since_fall != DIV + 1) tot_gap_bad++; end
      end else if (!p_inc) begin
        tot_pulses++;
        if (lo_cyc != DIV) tot_badw++;
        if (udn[0]) tot_ups++; else tot_dns++;
      end
      if (inc[0]) lo_cyc = 0;
    end else begin
      lo_cyc = 0;
      if (!p_csn) inc_at_rise = inc[0];
    end
    if (inc[1] !== 1'b1 || csn[1] !== 1'b1 || udn[1] !== 1'b0) tot_ch1_bad++;
    p_inc = inc[0]; p_csn = csn[0]; p_udn = udn[0];
  end

  task automatic bus(input logic w, input int ch, input logic r, input logic [31:0] d,
                     output logic [31:0] q, output int n);
    stb = 1'b1; cyc = 1'b1; we = w; adr = {26'd0, 3'(ch), r, 2'b00}; dat_i = d; n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 4);
    checks++;
    if (!ack) begin errors++; $display("FAIL bus_ack ch%0d got ack=0 want 1", ch); end
    q = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input int limit);
    logic [31:0] q; int n, waited;
    waited = 0;
    bus(1'b0, ch, 1'b1, 32'd0, q, n);
    while (q[8] && waited < limit) begin
      repeat (16) @(posedge clk); #1; waited += 16;
      bus(1'b0, ch, 1'b1, 32'd0, q, n);
    end
    checks++;
    if (q[8]) begin errors++; $display("FAIL idle_timeout ch%0d busy=1 want 0", ch); end
  endtask

  task automatic test_reset;
    logic [31:0] q; int n;
    reset = 1'b0;
    repeat (3) @(posedge clk); @(negedge clk);
    checks++;
    if (inc !== 2'b11 || csn !== 2'b11 || udn !== 2'b00) begin
      errors++; $display("FAIL reset_pins inc=%b csn=%b udn=%b want 11 11 00", inc, csn, udn);
    end
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'd0) begin
      errors++; $display("FAIL reset_bus ack=%b dat=%h want 0 0", ack, dat_o);
    end
    reset = 1'b1; @(posedge clk); #1;
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_status got=%h want=0", q); end
    bus(1'b0, 0, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_target got=%h want=0", q); end
  endtask

  task automatic test_home;
    logic [31:0] q; int n, u0, d0, b0;
    u0 = tot_ups; d0 = tot_dns; b0 = tot_badw;
    bus(1'b1, 0, 1'b1, 32'h1, q, n);
    repeat (20) @(posedge clk); #1;
    bus(1'b1, 0, 1'b1, 32'h1, q, n);
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h500) begin errors++; $display("FAIL home_rejected got=%h want=500", q); end
    wait_idle(0, 3000);
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h600) begin errors++; $display("FAIL home_status got=%h want=600", q); end
    checks++;
    if (tot_dns - d0 != 100 || tot_ups != u0) begin
      errors++; $display("FAIL home_pulses down=%0d up=%0d want 100 0", tot_dns - d0, tot_ups - u0);
    end
    checks++; if (tot_badw != b0) begin errors++; $display("FAIL home_width bad=%0d want 0", tot_badw - b0); end
  endtask

  task automatic test_up_move;
    logic [31:0] q; int n, u0, p0, c0, b0, g0;
    u0 = tot_ups; p0 = tot_pulses; c0 = tot_csn_low; b0 = tot_badw; g0 = tot_gap_bad;
    bus(1'b1, 0, 1'b0, 32'h005, q, n);
    repeat (52) @(posedge clk); #1;
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h305) begin errors++; $display("FAIL up_busy_last got=%h want=305", q); end
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h205) begin errors++; $display("FAIL up_status got=%h want=205", q); end
    checks++;
    if (tot_ups - u0 != 5 || tot_pulses - p0 != 5) begin
      errors++; $display("FAIL up_pulses up=%0d total=%0d want 5 5", tot_ups - u0, tot_pulses - p0);
    end
    checks++; if (tot_csn_low - c0 != 48) begin errors++; $display("FAIL up_csn_low got=%0d want=48", tot_csn_low - c0); end
    checks++; if (tot_badw != b0) begin errors++; $display("FAIL up_width bad=%0d want 0", tot_badw - b0); end
    checks++; if (tot_gap_bad != g0) begin errors++; $display("FAIL up_first_inc gap_bad=%0d want 0", tot_gap_bad - g0); end
    checks++; if (inc_at_rise !== 1'b0) begin errors++; $display("FAIL up_no_store inc=%b want 0", inc_at_rise); end
  endtask

  task automatic test_store_down;
    logic [31:0] q; int n, u0, d0;
    u0 = tot_ups; d0 = tot_dns;
    bus(1'b1, 0, 1'b0, 32'h102, q, n);
    wait_idle(0, 500);
    checks++;
    if (tot_dns - d0 != 3 || tot_ups != u0) begin
      errors++; $display("FAIL down_pulses down=%0d up=%0d want 3 0", tot_dns - d0, tot_ups - u0);
    end
    checks++; if (inc_at_rise !== 1'b1) begin errors++; $display("FAIL store_inc got=%b want 1", inc_at_rise); end
    bus(1'b0, 0, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'h002) begin errors++; $display("FAIL store_target got=%h want=002", q); end
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h202) begin errors++; $display("FAIL down_status got=%h want=202", q); end
  endtask

  task automatic test_reversal;
    logic [31:0] q; int n, k, p0, u0, d0, f0, g0;
    p0 = tot_pulses; u0 = tot_ups; d0 = tot_dns; f0 = tot_falls; g0 = tot_glitch;
    bus(1'b1, 0, 1'b0, 32'h00A, q, n);
    k = 0;
    while (tot_pulses < p0 + 2 && k < 400) begin @(negedge clk); k++; end
    checks++; if (tot_pulses < p0 + 2) begin errors++; $display("FAIL rev_wait pulses=%0d want 2", tot_pulses - p0); end
    bus(1'b1, 0, 1'b0, 32'h002, q, n);
    wait_idle(0, 1000);
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h202) begin errors++; $display("FAIL rev_status got=%h want=202", q); end
    checks++;
    if (tot_ups - u0 != 2 || tot_dns - d0 != 2) begin
      errors++; $display("FAIL rev_pulses up=%0d down=%0d want 2 2", tot_ups - u0, tot_dns - d0);
    end
    checks++; if (tot_falls - f0 != 2) begin errors++; $display("FAIL rev_selects got=%0d want=2", tot_falls - f0); end
    checks++; if (tot_glitch != g0) begin errors++; $display("FAIL rev_udn_glitch got=%0d want 0", tot_glitch - g0); end
  endtask

  task automatic test_clamp;
    logic [31:0] q; int n;
    bus(1'b1, 0, 1'b0, 32'h07F, q, n);
    bus(1'b0, 0, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'h063) begin errors++; $display("FAIL clamp_target got=%h want=063", q); end
    wait_idle(0, 3000);
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'h263) begin errors++; $display("FAIL clamp_status got=%h want=263", q); end
    bus(1'b1, 0, 1'b0, 32'h064, q, n);
    bus(1'b0, 0, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'h063) begin errors++; $display("FAIL clamp_100 got=%h want=063", q); end
  endtask

  task automatic test_bus_edge;
    logic [31:0] q; int n; logic a0, a1, a2;
    @(posedge clk); #1;
    bus(1'b1, 5, 1'b0, 32'h010, q, n);
    checks++; if (n != 1) begin errors++; $display("FAIL ch5_write_edges got=%0d want=1", n); end
    @(posedge clk); #1;
    bus(1'b0, 5, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'd0 || n != 1) begin errors++; $display("FAIL ch5_read got=%h edges=%0d want 0 1", q, n); end
    bus(1'b0, 0, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'h063) begin errors++; $display("FAIL ch0_intact got=%h want=063", q); end
    bus(1'b0, 1, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL ch1_status got=%h want=0", q); end
    checks++; if (tot_ch1_bad != 0) begin errors++; $display("FAIL ch1_idle_pins bad=%0d want 0", tot_ch1_bad); end
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'd0;
    @(posedge clk); #1; a0 = ack;
    @(posedge clk); #1; a1 = ack;
    @(posedge clk); #1; a2 = ack;
    stb = 1'b0; cyc = 1'b0;
    checks++; if ({a0, a1, a2} !== 3'b101) begin errors++; $display("FAIL b2b_ack got=%b want=101", {a0, a1, a2}); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q; int n;
    bus(1'b1, 0, 1'b0, 32'h132, q, n);
    bus(1'b1, 1, 1'b0, 32'h003, q, n);
    repeat (10) @(posedge clk); @(negedge clk);
    checks++;
    if (csn !== 2'b00 || udn !== 2'b10) begin
      errors++; $display("FAIL both_active csn=%b udn=%b want 00 10", csn, udn);
    end
    reset = 1'b0; #1;
    checks++;
    if (inc !== 2'b11 || csn !== 2'b11 || udn !== 2'b00) begin
      errors++; $display("FAIL reset_async inc=%b csn=%b udn=%b want 11 11 00", inc, csn, udn);
    end
    @(negedge clk);
    checks++;
    if (inc !== 2'b11 || csn !== 2'b11 || udn !== 2'b00 || ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid inc=%b csn=%b udn=%b ack=%b want 11 11 00 0", inc, csn, udn, ack);
    end
    reset = 1'b1; @(posedge clk); #1;
    bus(1'b0, 0, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_mid_status0 got=%h want=0", q); end
    bus(1'b0, 1, 1'b1, 32'd0, q, n);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_mid_status1 got=%h want=0", q); end
    bus(1'b0, 0, 1'b0, 32'd0, q, n);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_mid_target got=%h want=0", q); end
  endtask

  initial begin
    test_reset();
    test_home();
    test_up_move();
    test_store_down();
    test_reversal();
    test_clamp();
    test_bus_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
